// File: rtl/div_share_arbiter.sv
// Shares one pipelined unsigned divider among N_REQ requesters: round-robin issue, in-order
// tag tracking, per-requester result routing and round collection with flush/drain.
module div_share_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned I_W     = 50,
    parameter int unsigned D_W     = 38,
    parameter int unsigned O_W     = 12,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*I_W-1:0] req_dividend,
    input  logic [N_REQ*D_W-1:0] req_divisor,
    output logic                 div_valid_i,
    output logic [I_W-1:0]       div_dividend,
    output logic [D_W-1:0]       div_divisor,
    input  logic                 div_valid_o,
    input  logic [O_W-1:0]       div_quotient,
    output logic [N_REQ-1:0]     res_valid,
    output logic [N_REQ*O_W-1:0] res_quot,
    output logic                 round_done,
    input  logic                 flush,
    output logic                 busy,
    output logic                 err_orphan
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               rr_q, rr_d;
    logic [N_REQ-1:0]               collected_q, collected_d;
    logic [MAX_OUT-1:0][IDX_W-1:0]  tag_idx_q, tag_idx_d;
    logic [MAX_OUT-1:0]             tag_zdiv_q, tag_zdiv_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           div_valid_q, div_valid_d;
    logic [I_W-1:0]                 div_dividend_q, div_dividend_d;
    logic [D_W-1:0]                 div_divisor_q, div_divisor_d;
    logic [N_REQ-1:0]               res_valid_q, res_valid_d;
    logic [N_REQ*O_W-1:0]           res_quot_q, res_quot_d;
    logic                           round_done_q, round_done_d;
    logic                           err_orphan_q, err_orphan_d;

    logic [N_REQ-1:0] eligible;
    logic             found, accept, pop, full;
    logic [IDX_W-1:0] winner, head_idx;
    logic [I_W-1:0]   win_dividend;
    logic [D_W-1:0]   win_divisor;

    assign eligible = req_valid & ~collected_q;
    assign full     = (cnt_q == CNT_W'(MAX_OUT));
    assign pop      = div_valid_o && (cnt_q != '0);
    assign head_idx = tag_idx_q[rd_ptr_q];
    // A full FIFO still accepts when a result frees a slot in the same cycle.
    assign accept   = (state_q == StRun) && !flush && found && (!full || pop);

    always_comb begin
        found        = 1'b0;
        winner       = '0;
        win_dividend = '0;
        win_divisor  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            int unsigned j;
            j = (32'(rr_q) + i) % N_REQ;
            if (!found && eligible[IDX_W'(j)]) begin
                found  = 1'b1;
                winner = IDX_W'(j);
            end
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (winner == IDX_W'(k)) begin
                win_dividend = req_dividend[k*I_W +: I_W];
                win_divisor  = req_divisor[k*D_W +: D_W];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        tag_idx_d      = tag_idx_q;
        tag_zdiv_d     = tag_zdiv_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        cnt_d          = cnt_q;
        div_valid_d    = accept;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        res_valid_d    = '0;
        res_quot_d     = res_quot_q;
        collected_d    = round_done_q ? '0 : collected_q;
        round_done_d   = 1'b0;
        err_orphan_d   = err_orphan_q | (div_valid_o && (cnt_q == '0));

        case (state_q)
            StRun:   if (flush) state_d = StDrain;
            StDrain: if (cnt_q == '0) state_d = StClear;
            StClear: state_d = StRun;
            default: state_d = StRun;
        endcase

        if (accept) begin
            rr_d                 = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            tag_idx_d[wr_ptr_q]  = winner;
            tag_zdiv_d[wr_ptr_q] = (win_divisor == '0);
            wr_ptr_d             = (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
            div_dividend_d       = win_dividend;
            div_divisor_d        = win_divisor;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (head_idx == IDX_W'(k)) begin
                    res_valid_d[k]             = 1'b1;
                    collected_d[k]             = 1'b1;
                    res_quot_d[k*O_W +: O_W]   = tag_zdiv_q[rd_ptr_q] ? '1 : div_quotient;
                end
            end
            round_done_d = (state_q == StRun) && (&collected_d);
        end

        if (accept && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (state_q == StClear) begin
            collected_d = '0;
            res_quot_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            rr_q           <= '0;
            collected_q    <= '0;
            tag_idx_q      <= '0;
            tag_zdiv_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            div_valid_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            res_valid_q    <= '0;
            res_quot_q     <= '0;
            round_done_q   <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            collected_q    <= collected_d;
            tag_idx_q      <= tag_idx_d;
            tag_zdiv_q     <= tag_zdiv_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            div_valid_q    <= div_valid_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            res_valid_q    <= res_valid_d;
            res_quot_q     <= res_quot_d;
            round_done_q   <= round_done_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

    assign req_ready    = accept ? (N_REQ'(1) << winner) : '0;
    assign div_valid_i  = div_valid_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;
    assign res_valid    = res_valid_q;
    assign res_quot     = res_quot_q;
    assign round_done   = round_done_q;
    assign busy         = (state_q != StRun) || (cnt_q != '0);
    assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: behavioural pipelined divider plus an in-order scoreboard of
// expected (owner, quotient) pairs filled on grants and drained on res_valid.
module tb_div_share_arbiter;

    localparam int N   = 4;
    localparam int I_W = 50;
    localparam int D_W = 38;
    localparam int O_W = 12;

    typedef struct { int idx; logic [O_W-1:0] q; } exp_t;
    typedef struct { logic [I_W-1:0] dnd; logic [D_W-1:0] dsr; } iss_t;
    typedef struct { logic [I_W-1:0] dnd; logic [D_W-1:0] dsr; int due; } pipe_t;

    logic               clk, rst, flush;
    logic [N-1:0]       req_valid, req_ready, res_valid;
    logic [N*I_W-1:0]   req_dividend;
    logic [N*D_W-1:0]   req_divisor;
    logic               div_valid_i, div_valid_o, round_done, busy, err_orphan;
    logic [I_W-1:0]     div_dividend;
    logic [D_W-1:0]     div_divisor;
    logic [O_W-1:0]     div_quotient;
    logic [N*O_W-1:0]   res_quot;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, lat = 5, ret_credit = -1;
    bit force_orphan = 0;
    int res_count = 0, rd_count = 0, rd_cyc = 0, gcount = 0, last_res_cyc = 0;
    int res_cyc[N];
    int glog_idx[$], glog_cyc[$];
    exp_t  exp_q[$];
    iss_t  iss_q[$];
    pipe_t pipe[$];
    exp_t  me;
    iss_t  mi;
    pipe_t mp, dp;
    logic [I_W-1:0] mtmp;

    div_share_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .div_valid_i(div_valid_i),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_valid_o(div_valid_o),
        .div_quotient(div_quotient), .res_valid(res_valid), .res_quot(res_quot),
        .round_done(round_done), .flush(flush), .busy(busy), .err_orphan(err_orphan)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Divider model: fixed latency, in order, returns 5 for a zero divisor.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        div_valid_o = 1'b0;
        if (force_orphan) begin
            div_valid_o  = 1'b1;
            div_quotient = 12'h123;
            force_orphan = 0;
        end else if (pipe.size() > 0 && ret_credit != 0 && pipe[0].due <= cyc) begin
            dp = pipe.pop_front();
            div_valid_o = 1'b1;
            if (dp.dsr == '0) begin
                div_quotient = 12'h005;
            end else begin
                mtmp = dp.dnd / I_W'(dp.dsr);
                div_quotient = mtmp[O_W-1:0];
            end
            if (ret_credit > 0) ret_credit = ret_credit - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                n_tests++;
                if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
                    n_fail++;
                    $display("FAIL grant_onehot: got %b valid %b", req_ready, req_valid);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (req_ready[k] && req_valid[k]) begin
                    mi.dnd = req_dividend[k*I_W +: I_W];
                    mi.dsr = req_divisor[k*D_W +: D_W];
                    me.idx = k;
                    if (mi.dsr == '0) begin
                        me.q = '1;
                    end else begin
                        mtmp = mi.dnd / I_W'(mi.dsr);
                        me.q = mtmp[O_W-1:0];
                    end
                    exp_q.push_back(me);
                    iss_q.push_back(mi);
                    glog_idx.push_back(k);
                    glog_cyc.push_back(cyc);
                    gcount++;
                end
            end
            if (div_valid_i) begin
                n_tests++;
                if (iss_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue_unexpected: got issue, expected none");
                end else begin
                    mi = iss_q.pop_front();
                    if (div_dividend !== mi.dnd || div_divisor !== mi.dsr) begin
                        n_fail++;
                        $display("FAIL issue_operands: got %h/%h expected %h/%h",
                                 div_dividend, div_divisor, mi.dnd, mi.dsr);
                    end
                end
                mp.dnd = div_dividend;
                mp.dsr = div_divisor;
                mp.due = cyc + lat;
                pipe.push_back(mp);
            end
            if (res_valid != '0) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL res_unexpected: got res_valid %b, expected none", res_valid);
                end else begin
                    me = exp_q.pop_front();
                    if (res_valid !== (N'(1) << me.idx) || res_quot[me.idx*O_W +: O_W] !== me.q) begin
                        n_fail++;
                        $display("FAIL res_route: got %b q=%h expected lane %0d q=%h", res_valid,
                                 res_quot[me.idx*O_W +: O_W], me.idx, me.q);
                    end
                    res_cyc[me.idx] = cyc;
                end
                res_count++;
                last_res_cyc = cyc;
            end
            if (round_done) begin
                rd_count++;
                rd_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1; req_valid = '0; flush = 0; ret_credit = -1; force_orphan = 0;
        @(posedge clk); #2;
        pipe.delete(); exp_q.delete(); iss_q.delete();
        @(posedge clk); #2;
        rst = 0;
    endtask

    task automatic step(input bit drop);
        logic [N-1:0] g;
        @(negedge clk);
        g = req_ready & req_valid;
        @(posedge clk); #2;
        if (drop) req_valid = req_valid & ~g;
    endtask

    task automatic set_op(input int k, input logic [I_W-1:0] a, input logic [D_W-1:0] b);
        req_dividend[k*I_W +: I_W] = a;
        req_divisor[k*D_W +: D_W]  = b;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && pipe.size() == 0 && exp_q.size() == 0) break;
        end
        n_tests++;
        if (i == 200) begin
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b pending=%0d expected idle", busy, exp_q.size());
        end
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        do_reset();
        req_valid = '1;
        repeat (3) step(0);
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({req_ready, div_valid_i, res_valid, round_done, busy, err_orphan} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b iss=%b res=%b rd=%b busy=%b orph=%b expected 0",
                     req_ready, div_valid_i, res_valid, round_done, busy, err_orphan);
        end
        n_tests++;
        if (res_quot !== '0 || div_dividend !== '0 || div_divisor !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got quot=%h dnd=%h dsr=%h expected 0",
                     res_quot, div_dividend, div_divisor);
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_orphan: got %b expected 0", err_orphan);
        end
    endtask

    task automatic test_round();
        int gb, rb;
        logic [63:0] d;
        do_reset();
        lat = 5;
        for (int k = 0; k < N; k++) begin
            d = (k == 3) ? 64'h20_0000_0001 : 64'd1000 + 64'(13 * k);
            set_op(k, I_W'(64'((k + 1) * 10) * d + 64'd5), D_W'(d));
        end
        gb = glog_idx.size(); rb = rd_count;
        req_valid = '1;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (rd_count > rb) break;
        end
        repeat (3) step(1);
        n_tests++;
        if (rd_count - rb != 1) begin
            n_fail++;
            $display("FAIL round_done_count: got %0d expected 1", rd_count - rb);
        end
        n_tests++;
        if (glog_idx.size() - gb != 4) begin
            n_fail++;
            $display("FAIL round_grants: got %0d expected 4", glog_idx.size() - gb);
        end else begin
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (glog_idx[gb+k] != k || glog_cyc[gb+k] != glog_cyc[gb] + k ||
                    res_cyc[k] != glog_cyc[gb+k] + 7) begin
                    n_fail++;
                    $display("FAIL round_timing%0d: got idx %0d dt %0d lat %0d expected %0d %0d 7",
                             k, glog_idx[gb+k], glog_cyc[gb+k] - glog_cyc[gb],
                             res_cyc[k] - glog_cyc[gb+k], k, k);
                end
            end
        end
        n_tests++;
        if (rd_cyc != res_cyc[3]) begin
            n_fail++;
            $display("FAIL round_done_align: got cycle %0d expected %0d", rd_cyc, res_cyc[3]);
        end
        wait_idle();
    endtask

    task automatic test_zdiv();
        int rb;
        logic [O_W-1:0] want;
        do_reset();
        lat = 3;
        for (int k = 0; k < N; k++) set_op(k, I_W'((k + 1) * 100 * (7 + k) + 3), D_W'(7 + k));
        set_op(2, I_W'(12345), '0);
        rb = rd_count;
        req_valid = '1;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (rd_count > rb) break;
        end
        for (int k = 0; k < N; k++) begin
            want = (k == 2) ? 12'hFFF : O_W'((k + 1) * 100);
            n_tests++;
            if (res_quot[k*O_W +: O_W] !== want) begin
                n_fail++;
                $display("FAIL zdiv_lane%0d: got %h expected %h", k, res_quot[k*O_W +: O_W], want);
            end
        end
        wait_idle();
    endtask

    task automatic test_no_regrant();
        int rcb, bad;
        bit seen;
        logic [N-1:0] g;
        do_reset();
        lat = 5;
        for (int k = 0; k < N; k++) set_op(k, I_W'(3 * (k + 50)), D_W'(3));
        rcb = res_count;
        req_valid = 4'b0011;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (res_count >= rcb + 2) break;
        end
        req_valid = 4'b1110;
        bad = 0; seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (round_done) begin
                seen = 1;
                break;
            end
            if (req_ready[1]) bad++;
            g = req_ready & req_valid;
            @(posedge clk); #2;
            req_valid = req_valid & ~g;
        end
        n_tests++;
        if (bad != 0 || !seen) begin
            n_fail++;
            $display("FAIL regrant_blocked: got %0d early grants, round_done=%b expected 0, 1",
                     bad, seen);
        end
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL regrant_after_round: got %b expected 0010", req_ready);
        end
        @(posedge clk); #2;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_backpressure();
        int gb;
        do_reset();
        lat = 2;
        for (int k = 0; k < N; k++) set_op(k, I_W'(1000 + k), D_W'(10));
        gb = gcount;
        ret_credit = 0;
        req_valid = '1;
        repeat (8) step(0);
        @(negedge clk);
        n_tests++;
        if (gcount - gb != 4 || req_ready !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_stall: got %0d issues rdy=%b busy=%b expected 4 0000 1",
                     gcount - gb, req_ready, busy);
        end
        ret_credit = 1;
        @(negedge clk);
        n_tests++;
        if (div_valid_o !== 1'b1 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL full_pop_grant: got rdy=%b expected 0001", req_ready);
        end
        @(posedge clk); #2;
        req_valid = '0;
        ret_credit = -1;
        wait_idle();
    endtask

    task automatic test_flush();
        int gb, rb, rcb, i;
        do_reset();
        lat = 2;
        for (int k = 0; k < N; k++) set_op(k, I_W'(500 + 40 * k), D_W'(4));
        gb = gcount; rb = rd_count;
        ret_credit = 0;
        req_valid = 4'b0111;
        for (i = 0; i < 20; i++) begin
            step(1);
            if (gcount - gb >= 3) break;
        end
        repeat (2) step(1);
        rcb = res_count;
        flush = 1;
        step(1);
        flush = 0;
        req_valid = 4'b1000;
        @(negedge clk);
        n_tests++;
        if (req_ready !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_ctrl: got rdy=%b busy=%b expected 0000 1", req_ready, busy);
        end
        ret_credit = -1;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        n_tests++;
        if (res_count - rcb != 3 || rd_count != rb) begin
            n_fail++;
            $display("FAIL drain_results: got %0d res %0d round_done expected 3 0",
                     res_count - rcb, rd_count - rb);
        end
        n_tests++;
        if (busy !== 1'b0 || cyc != last_res_cyc + 2) begin
            n_fail++;
            $display("FAIL clear_timing: got busy=%b run at +%0d expected 0 +2",
                     busy, cyc - last_res_cyc);
        end
        n_tests++;
        if (res_quot !== '0 || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL clear_state: got quot=%h rdy=%b expected 0 1000", res_quot, req_ready);
        end
        @(posedge clk); #2;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_orphan();
        do_reset();
        @(negedge clk);
        force_orphan = 1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (err_orphan !== 1'b1 || res_valid !== '0) begin
            n_fail++;
            $display("FAIL orphan_set: got orph=%b res=%b expected 1 0000", err_orphan, res_valid);
        end
        @(posedge clk); #2;
        flush = 1;
        @(posedge clk); #2;
        flush = 0;
        repeat (6) @(negedge clk);
        n_tests++;
        if (err_orphan !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_sticky: got orph=%b busy=%b expected 1 0", err_orphan, busy);
        end
        do_reset();
        @(negedge clk);
        n_tests++;
        if (err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_rst: got %b expected 0", err_orphan);
        end
    endtask

    initial begin
        rst = 1; flush = 0; req_valid = '0;
        req_dividend = '0; req_divisor = '0;
        div_valid_o = 0; div_quotient = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_round();
        test_zdiv();
        test_no_regrant();
        test_backpressure();
        test_flush();
        test_orphan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
